// File: rtl/multicycle_datapath.sv
// Multi-cycle ARM datapath: FETCH/DECODE/EXECUTE/MEMORY/WRITEBACK over one req/ready memory port.
// Defining PERF_COUNT_EN adds the cycle_count and instr_count performance counter outputs.
module multicycle_datapath #(
  parameter int WIDTH = 32,
  parameter logic [WIDTH-1:0] RESET_PC = '0
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             PCSrc,
  input  logic [1:0]       RegSrc,
  input  logic             RegWrite,
  input  logic             ALUSrc,
  input  logic             ShiftSrc,
  input  logic [1:0]       ShamtSrc,
  input  logic [1:0]       ImmSrc,
  input  logic             LinkSrc,
  input  logic             BXSrc,
  input  logic             MemWrite,
  input  logic             MemtoReg,
  input  logic [3:0]       ALUControl,
  input  logic [3:0]       debug_source_select,
  output logic             mem_req,
  output logic             mem_we,
  output logic [WIDTH-1:0] mem_addr,
  output logic [WIDTH-1:0] mem_wdata,
  input  logic [WIDTH-1:0] mem_rdata,
  input  logic             mem_ready,
  output logic [WIDTH-1:0] Instr_out,
  output logic             zero_flag_out,
  output logic [WIDTH-1:0] PC_out,
  output logic [WIDTH-1:0] debug_out,
  output logic [2:0]       state_out,
`ifdef PERF_COUNT_EN
  output logic [WIDTH-1:0] cycle_count,
  output logic [WIDTH-1:0] instr_count,
`endif
  output logic             instr_retired
);

  typedef enum logic [2:0] {
    FETCH     = 3'd0,
    DECODE    = 3'd1,
    EXECUTE   = 3'd2,
    MEMORY    = 3'd3,
    WRITEBACK = 3'd4
  } state_t;

  state_t           r_state, w_nextState;
  logic [WIDTH-1:0] r_pc, r_ir, r_a, r_b, r_extImm, r_aluOut, r_dataReg;
  logic             r_zero;
  logic [WIDTH-1:0] r_regFile [0:14];

  logic [WIDTH-1:0] w_pcPlus4, w_pcPlus8, w_rd1, w_rd2, w_extImm;
  logic [WIDTH-1:0] w_shIn, w_shOut, w_aluResult, w_result;
  logic [3:0]       w_ra1, w_ra2, w_rd;
  logic [1:0]       w_shType;
  logic [4:0]       w_shamt;

  assign w_pcPlus4 = r_pc + WIDTH'(4);
  assign w_pcPlus8 = r_pc + WIDTH'(8);
  assign w_ra1     = RegSrc[0] ? 4'd15 : r_ir[19:16];
  assign w_ra2     = RegSrc[1] ? r_ir[15:12] : r_ir[3:0];
  assign w_rd      = r_ir[15:12];
  // Index 15 is the PC read port, which the pipeline-visible ARM semantics define as PC+8.
  assign w_rd1     = (w_ra1 == 4'd15) ? w_pcPlus8 : r_regFile[w_ra1];
  assign w_rd2     = (w_ra2 == 4'd15) ? w_pcPlus8 : r_regFile[w_ra2];
  assign debug_out = (debug_source_select == 4'd15) ? w_pcPlus8 : r_regFile[debug_source_select];

  always_comb begin
    w_extImm = '0;
    case (ImmSrc)
      2'b00:   w_extImm = {{(WIDTH-8){1'b0}}, r_ir[7:0]};
      2'b01:   w_extImm = {{(WIDTH-12){1'b0}}, r_ir[11:0]};
      2'b10:   w_extImm = {{(WIDTH-26){r_ir[23]}}, r_ir[23:0], 2'b00};
      default: w_extImm = '0;
    endcase
  end

  assign w_shIn   = ALUSrc ? r_b : r_extImm;
  assign w_shType = ShiftSrc ? r_ir[6:5] : 2'b11;

  always_comb begin
    w_shamt = '0;
    case (ShamtSrc)
      2'd1:    w_shamt = {r_ir[11:8], 1'b0};
      2'd2:    w_shamt = r_ir[11:7];
      default: w_shamt = '0;
    endcase
  end

  always_comb begin
    w_shOut = w_shIn;
    case (w_shType)
      2'b00:   w_shOut = w_shIn << w_shamt;
      2'b01:   w_shOut = w_shIn >> w_shamt;
      2'b10:   w_shOut = $unsigned($signed(w_shIn) >>> w_shamt);
      default: w_shOut = (w_shIn >> w_shamt) | (w_shIn << (WIDTH - int'(w_shamt)));
    endcase
  end

  // ALUControl follows the ARM data-processing opcode; carry-using ops behave as their carry-less forms.
  always_comb begin
    w_aluResult = r_a + w_shOut;
    case (ALUControl)
      4'b0000, 4'b1000:          w_aluResult = r_a & w_shOut;
      4'b0001, 4'b1001:          w_aluResult = r_a ^ w_shOut;
      4'b0010, 4'b0110, 4'b1010: w_aluResult = r_a - w_shOut;
      4'b0011, 4'b0111:          w_aluResult = w_shOut - r_a;
      4'b1100:                   w_aluResult = r_a | w_shOut;
      4'b1101:                   w_aluResult = w_shOut;
      4'b1110:                   w_aluResult = r_a & ~w_shOut;
      4'b1111:                   w_aluResult = ~w_shOut;
      default:                   w_aluResult = r_a + w_shOut;
    endcase
  end

  assign w_result = MemtoReg ? r_dataReg : (BXSrc ? r_aluOut : r_b);

  always_ff @(posedge clk) begin
    if (reset) r_state <= FETCH;
    else       r_state <= w_nextState;
  end

  always_comb begin
    w_nextState   = r_state;
    mem_req       = 1'b0;
    mem_we        = 1'b0;
    mem_addr      = r_pc;
    instr_retired = 1'b0;
    case (r_state)
      FETCH: begin
        mem_req = 1'b1;
        if (mem_ready) w_nextState = DECODE;
      end
      DECODE:  w_nextState = EXECUTE;
      EXECUTE: w_nextState = (MemWrite | MemtoReg) ? MEMORY : WRITEBACK;
      MEMORY: begin
        mem_req  = 1'b1;
        mem_we   = MemWrite;
        mem_addr = r_aluOut;
        if (mem_ready) w_nextState = WRITEBACK;
      end
      WRITEBACK: begin
        instr_retired = 1'b1;
        w_nextState   = FETCH;
      end
      default: w_nextState = FETCH;
    endcase
    // A reset cycle abandons any access in flight, so nothing is requested or retired.
    if (reset) begin
      mem_req       = 1'b0;
      mem_we        = 1'b0;
      instr_retired = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_pc      <= RESET_PC;
      r_ir      <= '0;
      r_a       <= '0;
      r_b       <= '0;
      r_extImm  <= '0;
      r_aluOut  <= '0;
      r_dataReg <= '0;
      r_zero    <= 1'b0;
      for (int i = 0; i < 15; i++) r_regFile[i] <= '0;
    end else begin
      case (r_state)
        FETCH:   if (mem_ready) r_ir <= mem_rdata;
        DECODE: begin
          r_a      <= w_rd1;
          r_b      <= w_rd2;
          r_extImm <= w_extImm;
        end
        EXECUTE: begin
          r_aluOut <= w_aluResult;
          r_zero   <= (w_aluResult == '0);
        end
        MEMORY:  if (mem_ready && MemtoReg) r_dataReg <= mem_rdata;
        WRITEBACK: begin
          // R15 is never a register-file target; the PC only moves through PCSrc.
          if (RegWrite) begin
            if (LinkSrc)              r_regFile[14]   <= w_pcPlus4;
            else if (w_rd != 4'd15)   r_regFile[w_rd] <= w_result;
          end
          r_pc <= PCSrc ? w_result : w_pcPlus4;
        end
        default: ;
      endcase
    end
  end

`ifdef PERF_COUNT_EN
  always_ff @(posedge clk) begin
    if (reset) begin
      cycle_count <= '0;
      instr_count <= '0;
    end else begin
      cycle_count <= cycle_count + WIDTH'(1);
      if (instr_retired) instr_count <= instr_count + WIDTH'(1);
    end
  end
`endif

  assign mem_wdata     = r_b;
  assign Instr_out     = r_ir;
  assign zero_flag_out = r_zero;
  assign PC_out        = r_pc;
  assign state_out     = r_state;

endmodule
